commit_sched: RTL

In-order writeback commit scheduler between the EXU/LSU writeback paths and the architectural state update (PC, two CSR write ports, GPR) plus the simulation commit hook.
- Dispatch records each instruction's writeback source, in program order, into an order FIFO.
- Only the requester at the FIFO head may commit.
- Exactly one registered commit record per cycle drives the register files and the difftest commit bridge.

---
 rtl/commit_pkg.sv | 34 +++
 rtl/commit_order_fifo.sv | 68 ++++++
 rtl/commit_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/commit_pkg.sv
`default_nettype none
// ============================================================================
// commit_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the in-order commit scheduler: datapath
// widths, writeback source tags and the commit record layout.
// Revision: 1.0 - initial release
// ============================================================================
package commit_pkg;

  localparam int XLEN   = 32;
  localparam int CSR_AW = 12;
  localparam int GPR_AW = 5;

  // Writeback source tags stored in the order FIFO
  localparam logic SRC_EXU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  typedef struct packed {
    logic              pc_wen;
    logic [XLEN-1:0]   new_pc;
    logic              csra_wen;
    logic [CSR_AW-1:0] csra_addr;
    logic [XLEN-1:0]   csra_data;
    logic              csrb_wen;
    logic [CSR_AW-1:0] csrb_addr;
    logic [XLEN-1:0]   csrb_data;
    logic              gpr_wen;
    logic [GPR_AW-1:0] gpr_addr;
    logic [XLEN-1:0]   gpr_data;
  } commit_rec_t;

endpackage
`default_nettype wire

// File: rtl/commit_order_fifo.sv
`default_nettype none
// ============================================================================
// commit_order_fifo
// ----------------------------------------------------------------------------
// Circular buffer of 1-bit writeback source tags kept in program order.
// Pointers carry an extra wrap bit so full/empty are told apart without a
// separate counter.
// Ports:
//   clock, reset       - clock, asynchronous active-high reset
//   push_i, din_i      - write a tag (ignored when full)
//   pop_i              - retire the head tag (ignored when empty)
//   flush_i            - drop all entries; overrides push/pop
//   head_o             - tag at the read pointer
//   full_o, empty_o    - occupancy flags
//   count_o            - occupancy (wr_ptr - rd_ptr)
// Revision: 1.0 - initial release
// ============================================================================
module commit_order_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;

  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // Full/empty are evaluated on the current pointers, so a pop never
      // frees a slot for a push in the same cycle.
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
        wr_ptr_q                   <= wr_ptr_q + PTR_ONE;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/commit_sched.sv
`default_nettype none
// ============================================================================
// commit_sched
// ----------------------------------------------------------------------------
// In-order writeback commit scheduler. Dispatch pushes each instruction's
// writeback source into an order FIFO; only the source at the FIFO head is
// granted, and the granted record is registered into a single commit record
// that drives PC/CSR/GPR update and the simulation commit hook.
// Ports:
//   clock, reset, flush          - clock, async reset, sync pipeline flush
//   iss_valid/iss_ready/iss_src  - dispatch push of the writeback source
//   exu_*                        - EXU commit record and handshake
//   lsu_*                        - LSU commit record and handshake
//   cm_*                         - registered commit record (latency 1)
//   pending                      - order-FIFO occupancy
// Revision: 1.0 - initial release
// ============================================================================
module commit_sched
  import commit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic              iss_src,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic              exu_pc_wen,
  input  logic [XLEN-1:0]   exu_new_pc,
  input  logic              exu_csra_wen,
  input  logic [CSR_AW-1:0] exu_csra_addr,
  input  logic [XLEN-1:0]   exu_csra_data,
  input  logic              exu_csrb_wen,
  input  logic [CSR_AW-1:0] exu_csrb_addr,
  input  logic [XLEN-1:0]   exu_csrb_data,
  input  logic              exu_gpr_wen,
  input  logic [GPR_AW-1:0] exu_gpr_addr,
  input  logic [XLEN-1:0]   exu_gpr_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic              lsu_pc_wen,
  input  logic [XLEN-1:0]   lsu_new_pc,
  input  logic              lsu_gpr_wen,
  input  logic [GPR_AW-1:0] lsu_gpr_addr,
  input  logic [XLEN-1:0]   lsu_gpr_data,
  output logic              cm_valid,
  output logic              cm_pc_wen,
  output logic              cm_csra_wen,
  output logic              cm_csrb_wen,
  output logic              cm_gpr_wen,
  output logic [XLEN-1:0]   cm_new_pc,
  output logic [XLEN-1:0]   cm_csra_data,
  output logic [XLEN-1:0]   cm_csrb_data,
  output logic [XLEN-1:0]   cm_gpr_data,
  output logic [CSR_AW-1:0] cm_csra_addr,
  output logic [CSR_AW-1:0] cm_csrb_addr,
  output logic [GPR_AW-1:0] cm_gpr_addr,
  output logic [PTR_W:0]    pending
);

  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic push;
  logic pop;
  logic exu_pop;
  logic lsu_pop;

  commit_rec_t exu_rec;
  commit_rec_t lsu_rec;
  commit_rec_t cm_d;
  commit_rec_t cm_q;
  logic        cm_valid_d;
  logic        cm_valid_q;

  // --------------------------------------------------------------------------
  // Order FIFO and handshakes
  // --------------------------------------------------------------------------
  assign iss_ready = !fifo_full;
  assign push      = iss_valid && iss_ready && !flush;

  assign exu_ready = !fifo_empty && (fifo_head == SRC_EXU) && !flush;
  assign lsu_ready = !fifo_empty && (fifo_head == SRC_LSU) && !flush;
  assign exu_pop   = exu_valid && exu_ready;
  assign lsu_pop   = lsu_valid && lsu_ready;
  // Grants are mutually exclusive through the head tag, so at most one pops.
  assign pop       = exu_pop || lsu_pop;

  commit_order_fifo #(
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .din_i   (iss_src),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (pending)
  );

  // --------------------------------------------------------------------------
  // Source records; GPR x0 is never written, LSU never writes CSRs
  // --------------------------------------------------------------------------
  always_comb begin
    exu_rec           = '0;
    exu_rec.pc_wen    = exu_pc_wen;
    exu_rec.new_pc    = exu_new_pc;
    exu_rec.csra_wen  = exu_csra_wen;
    exu_rec.csra_addr = exu_csra_addr;
    exu_rec.csra_data = exu_csra_data;
    exu_rec.csrb_wen  = exu_csrb_wen;
    exu_rec.csrb_addr = exu_csrb_addr;
    exu_rec.csrb_data = exu_csrb_data;
    exu_rec.gpr_wen   = exu_gpr_wen && (exu_gpr_addr != '0);
    exu_rec.gpr_addr  = exu_gpr_addr;
    exu_rec.gpr_data  = exu_gpr_data;
  end

  always_comb begin
    lsu_rec          = '0;
    lsu_rec.pc_wen   = lsu_pc_wen;
    lsu_rec.new_pc   = lsu_new_pc;
    lsu_rec.gpr_wen  = lsu_gpr_wen && (lsu_gpr_addr != '0);
    lsu_rec.gpr_addr = lsu_gpr_addr;
    lsu_rec.gpr_data = lsu_gpr_data;
  end

  // --------------------------------------------------------------------------
  // Commit register: idle cycles drop the enables but keep data/address so
  // the downstream buses do not toggle needlessly.
  // --------------------------------------------------------------------------
  always_comb begin
    cm_d          = cm_q;
    cm_d.pc_wen   = 1'b0;
    cm_d.csra_wen = 1'b0;
    cm_d.csrb_wen = 1'b0;
    cm_d.gpr_wen  = 1'b0;
    cm_valid_d    = pop;
    if (exu_pop) begin
      cm_d = exu_rec;
    end else if (lsu_pop) begin
      cm_d = lsu_rec;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cm_q       <= '0;
      cm_valid_q <= 1'b0;
    end else begin
      cm_q       <= cm_d;
      cm_valid_q <= cm_valid_d;
    end
  end

  assign cm_valid     = cm_valid_q;
  assign cm_pc_wen    = cm_q.pc_wen;
  assign cm_new_pc    = cm_q.new_pc;
  assign cm_csra_wen  = cm_q.csra_wen;
  assign cm_csra_addr = cm_q.csra_addr;
  assign cm_csra_data = cm_q.csra_data;
  assign cm_csrb_wen  = cm_q.csrb_wen;
  assign cm_csrb_addr = cm_q.csrb_addr;
  assign cm_csrb_data = cm_q.csrb_data;
  assign cm_gpr_wen   = cm_q.gpr_wen;
  assign cm_gpr_addr  = cm_q.gpr_addr;
  assign cm_gpr_data  = cm_q.gpr_data;

endmodule
`default_nettype wire
